// File: rtl/mc_control_fsm_if.sv
// Control/status bundle between the multi-cycle control FSM (master) and the
// RV32I datapath (slave).
interface mc_control_fsm_if;
  logic [6:0] opcode;
  logic       mem_ready;
  logic       ecall_halt_cond;
  logic       pc_write;
  logic       pc_write_cond;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_write;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       pc_source;
  logic       is_halted;

  modport master (
    input  opcode, mem_ready, ecall_halt_cond,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
           is_halted
  );

  modport slave (
    output opcode, mem_ready, ecall_halt_cond,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
           is_halted
  );
endinterface

// File: rtl/mc_control_fsm.sv
// Multi-cycle RV32I control unit: one datapath micro-step per cycle, Moore
// decode of the state, stalls on memory ready, halts on ECALL with x17 == 10.
module mc_control_fsm #(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  mc_control_fsm_if.master  bus
);

  typedef enum logic [3:0] {
    S_IF       = 4'd0,
    S_ID       = 4'd1,
    S_EX_R     = 4'd2,
    S_EX_I     = 4'd3,
    S_EX_ADDR  = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_WB_ALU   = 4'd7,
    S_WB_MEM   = 4'd8,
    S_EX_BR    = 4'd9,
    S_EX_JAL   = 4'd10,
    S_EX_JALR  = 4'd11,
    S_JALR_WB  = 4'd12,
    S_EX_ECALL = 4'd13,
    S_HALT     = 4'd14
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_SYS   = 7'b1110011;

  localparam logic [1:0] A_PC = 2'd0, A_RS1 = 2'd1, A_OLDPC = 2'd2;
  localparam logic [1:0] B_RS2 = 2'd0, B_FOUR = 2'd1, B_IMM = 2'd2;
  localparam logic [1:0] ALU_ADD = 2'd0, ALU_BR = 2'd1, ALU_FN = 2'd2;

  state_t state;
  logic   rdy;

  // With wait states disabled every memory access completes in one cycle.
  assign rdy = !MEM_WAIT_EN || bus.mem_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IF;
    end else begin
      case (state)
        S_IF:       if (rdy) state <= S_ID;
        S_ID: begin
          case (bus.opcode)
            OP_R:             state <= S_EX_R;
            OP_I:             state <= S_EX_I;
            OP_LOAD,
            OP_STORE:         state <= S_EX_ADDR;
            OP_BR:            state <= S_EX_BR;
            OP_JAL:           state <= S_EX_JAL;
            OP_JALR:          state <= S_EX_JALR;
            OP_SYS:           state <= S_EX_ECALL;
            default:          state <= S_IF;  // NOP: PC already advanced in IF
          endcase
        end
        S_EX_R,
        S_EX_I:     state <= S_WB_ALU;
        S_EX_ADDR:  state <= (bus.opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD:   if (rdy) state <= S_WB_MEM;
        S_MEM_WR:   if (rdy) state <= S_IF;
        S_WB_ALU,
        S_WB_MEM,
        S_EX_BR,
        S_EX_JAL,
        S_JALR_WB:  state <= S_IF;
        S_EX_JALR:  state <= S_JALR_WB;
        S_EX_ECALL: state <= bus.ecall_halt_cond ? S_HALT : S_IF;
        S_HALT:     state <= S_HALT;
        default:    state <= S_IF;
      endcase
    end
  end

  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_write, pc_source, is_halted;
  logic [1:0] alu_src_a, alu_src_b, alu_op;

  // Reset masks every strobe so an in-flight access is dropped that same cycle.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    pc_source     = 1'b0;
    is_halted     = 1'b0;
    alu_src_a     = A_PC;
    alu_src_b     = B_RS2;
    alu_op        = ALU_ADD;
    if (!reset) begin
      case (state)
        S_IF: begin
          mem_read  = 1'b1;
          alu_src_b = B_FOUR;
          pc_write  = rdy;
          ir_write  = rdy;
        end
        S_ID: begin
          alu_src_a = A_OLDPC;
          alu_src_b = B_IMM;
        end
        S_EX_R: begin
          alu_src_a = A_RS1;
          alu_op    = ALU_FN;
        end
        S_EX_I: begin
          alu_src_a = A_RS1;
          alu_src_b = B_IMM;
          alu_op    = ALU_FN;
        end
        S_EX_ADDR,
        S_EX_JALR: begin
          alu_src_a = A_RS1;
          alu_src_b = B_IMM;
        end
        S_MEM_RD: begin
          i_or_d   = 1'b1;
          mem_read = 1'b1;
        end
        S_MEM_WR: begin
          i_or_d    = 1'b1;
          mem_write = 1'b1;
        end
        S_WB_ALU: reg_write = 1'b1;
        S_WB_MEM: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_EX_BR: begin
          alu_src_a     = A_RS1;
          alu_op        = ALU_BR;
          pc_write_cond = 1'b1;
          pc_source     = 1'b1;
        end
        // Link value old_pc+4 comes off the ALU while the target sits in ALUOut.
        S_EX_JAL,
        S_JALR_WB: begin
          alu_src_a = A_OLDPC;
          alu_src_b = B_FOUR;
          reg_write = 1'b1;
          pc_write  = 1'b1;
          pc_source = 1'b1;
        end
        S_HALT:   is_halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.pc_write      = pc_write;
  assign bus.pc_write_cond = pc_write_cond;
  assign bus.i_or_d        = i_or_d;
  assign bus.mem_read      = mem_read;
  assign bus.mem_write     = mem_write;
  assign bus.ir_write      = ir_write;
  assign bus.mem_to_reg    = mem_to_reg;
  assign bus.reg_write     = reg_write;
  assign bus.alu_src_a     = alu_src_a;
  assign bus.alu_src_b     = alu_src_b;
  assign bus.alu_op        = alu_op;
  assign bus.pc_source     = pc_source;
  assign bus.is_halted     = is_halted;

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
Multi-cycle control unit for the RV32I multi-cycle CPU. It sequences the shared datapath (PC, IR, memory, ALU, register file) one micro-step per cycle. It issues the register-file write_enable (reg_write) only in writeback states. It stalls on a memory ready handshake, and halts on ECALL when the datapath reports x17 == 10.

Parameters:
MEM_WAIT_EN, 1, 1: memory states hold until mem_ready=1; 0: mem_ready ignored, memory is single-cycle.

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high
opcode  input  7  IR[6:0], valid from ID onward
mem_ready  input  1  memory access completes this cycle
ecall_halt_cond  input  1  rs1 data of x17 == 10 (datapath compare)
pc_write  output  1  unconditional PC update
pc_write_cond  output  1  PC update if ALU bcond true
i_or_d  output  1  0=instr addr (PC), 1=data addr (ALUOut)
mem_read  output  1  memory read strobe
mem_write  output  1  memory write strobe
ir_write  output  1  latch instruction (also latches old_pc)
mem_to_reg  output  1  0=ALUOut, 1=MDR to rd_din
reg_write  output  1  drives register-file write_enable
alu_src_a  output  2  0=PC, 1=rs1, 2=old_pc
alu_src_b  output  2  0=rs2, 1=const 4, 2=imm
alu_op  output  2  0=add, 1=branch compare, 2=funct-decoded
pc_source  output  1  0=ALU result, 1=ALUOut
is_halted  output  1  CPU halted

Behaviour:
- State register 4 bits. Synchronous reset puts it in IF. While reset=1, all outputs are 0.
- Outputs are Moore: a combinational decode of the state only. Any output not listed for a state is 0.
- IF
  - Asserts i_or_d=0, mem_read, ir_write, alu_src_a=0, alu_src_b=1, alu_op=0, pc_source=0.
  - pc_write and ir_write assert only in the cycle mem_ready=1, or every IF cycle when MEM_WAIT_EN=0.
  - Transitions to ID on mem_ready; otherwise stays in IF.
- ID
  - alu_src_a=2, alu_src_b=2, alu_op=0. ALUOut receives the branch/jump target old_pc+imm.
  - Next state is decoded from opcode:
    - 0110011 -> EX_R
    - 0010011 -> EX_I
    - 0000011 or 0100011 -> EX_ADDR
    - 1100011 -> EX_BR
    - 1101111 -> EX_JAL
    - 1100111 -> EX_JALR
    - 1110011 -> EX_ECALL
    - any other opcode -> IF (treated as NOP; PC was already advanced)
- EX_R: alu_src_a=1, alu_src_b=0, alu_op=2 -> WB_ALU.
- EX_I: alu_src_a=1, alu_src_b=2, alu_op=2 -> WB_ALU.
- EX_ADDR: alu_src_a=1, alu_src_b=2, alu_op=0. Goes to MEM_RD if opcode is a load, otherwise MEM_WR.
- MEM_RD: i_or_d=1, mem_read. Goes to WB_MEM on mem_ready; otherwise holds.
- MEM_WR: i_or_d=1, mem_write. Goes to IF on mem_ready; otherwise holds.
- WB_ALU: reg_write, mem_to_reg=0 -> IF.
- WB_MEM: reg_write, mem_to_reg=1 -> IF.
- EX_BR: alu_src_a=1, alu_src_b=0, alu_op=1, pc_write_cond, pc_source=1 -> IF.
- EX_JAL
  - alu_src_a=2, alu_src_b=1, alu_op=0. rd_din takes old_pc+4 via the ALU result path.
  - reg_write, pc_write, pc_source=1 -> IF.
- EX_JALR
  - Cycle 1: alu_src_a=1, alu_src_b=2, alu_op=0 (ALUOut=rs1+imm) -> JALR_WB.
  - JALR_WB: alu_src_a=2, alu_src_b=1, reg_write, pc_write, pc_source=1 -> IF.
- EX_ECALL: goes to HALT if ecall_halt_cond, otherwise to IF. No outputs asserted.
- HALT: is_halted=1, all strobes 0. HALT is absorbing; only reset exits it.
- reg_write is never asserted outside WB_ALU, WB_MEM, EX_JAL and JALR_WB. x0 protection remains in the register file.
- Reset asserted mid-instruction (any state, including a MEM_* wait):
  - Next cycle is IF.
  - No strobe is asserted during the reset cycle.
  - An in-flight memory access is abandoned.
- Undriven opcode during IF is a don't-care.
- Cycle counts with zero wait states:
  - R-type, I-arith: 4
  - load: 5
  - store: 4
  - branch: 3
  - JAL: 3
  - JALR: 4
  - ECALL: 3

Test Plan:
- Reset held 2 cycles, then released with mem_ready=1 -> first post-reset cycle is IF with mem_read=1, pc_write=1; all outputs 0 during reset.
- add (0110011), mem_ready=1 -> states IF,ID,EX_R,WB_ALU; reg_write=1 only in cycle 4 with mem_to_reg=0; next fetch in cycle 5.
- lw (0000011) with mem_ready low for 3 cycles in MEM_RD -> MEM_RD held 4 cycles, then WB_MEM with reg_write=1, mem_to_reg=1; total 8 cycles.
- sw (0100011) and beq (1100011) -> mem_write=1 with i_or_d=1 for exactly 1 cycle and reg_write never asserted; beq asserts pc_write_cond, pc_source=1 in its third cycle.
- Unknown opcode 0000000 -> returns to IF after ID (2 cycles), reg_write/mem_write never asserted.
- ECALL with ecall_halt_cond=1 -> HALT after 3 cycles, is_halted=1 held for 20 cycles; reset then returns to IF with is_halted=0. Separately, reset during a MEM_WR wait -> mem_write drops in the reset cycle, and IF follows.
